// File: rtl/sw_host_sequencer_pkg.sv
// Shared types and widths for the host-side FPGAWrapper sequencer.
package sw_host_sequencer_pkg;

  localparam int unsigned V_E_F_BIT = 16;
  localparam int unsigned PARAM_W   = 16;

  // Scoring parameters as presented to the FPGAWrapper, MSB nibble first.
  typedef struct packed {
    logic [3:0] match;
    logic [3:0] mismatch;
    logic [3:0] minus_alpha;
    logic [3:0] minus_beta;
  } score_param_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPULSE = 3'd1,
    ST_SETUP  = 3'd2,
    ST_CPULSE = 3'd3,
    ST_GUARD  = 3'd4,
    ST_WVALID = 3'd5,
    ST_DRAIN  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/sw_host_sequencer_if.sv
// Command/result handshake plus FPGAWrapper control bus around the sequencer.
interface sw_host_sequencer_if;
  import sw_host_sequencer_pkg::*;

  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic                 i_cmd_sett;
  score_param_t         i_cmd_param;
  logic                 o_res_valid;
  logic                 i_res_ready;
  logic [V_E_F_BIT-1:0] o_res_data;
  logic                 o_timeout;
  logic                 o_set_t;
  logic                 o_start_cal;
  score_param_t         o_param;
  logic                 i_busy;
  logic                 i_valid;
  logic [V_E_F_BIT-1:0] i_result;

  // Sequencer side.
  modport master (
    input  i_cmd_valid, i_cmd_sett, i_cmd_param, i_res_ready,
    input  i_busy, i_valid, i_result,
    output o_cmd_ready, o_res_valid, o_res_data, o_timeout,
    output o_set_t, o_start_cal, o_param
  );

  // Command source / FPGAWrapper side.
  modport slave (
    output i_cmd_valid, i_cmd_sett, i_cmd_param, i_res_ready,
    output i_busy, i_valid, i_result,
    input  o_cmd_ready, o_res_valid, o_res_data, o_timeout,
    input  o_set_t, o_start_cal, o_param
  );

endinterface

// File: rtl/sw_host_sequencer_watchdog.sv
// Clearable up-counter with a terminal-count flag for the wait-state watchdog.
module sw_host_sequencer_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles; clear wins so each state entry restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/sw_host_sequencer.sv
// Host-side initiator for FPGAWrapper: set_t / start_cal pulses, busy tracking,
// result capture with a watchdog abort on wait states.
module sw_host_sequencer
  import sw_host_sequencer_pkg::*;
#(
  parameter int unsigned GUARD_CYC   = 2,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  sw_host_sequencer_if.master bus
);

  localparam int unsigned PH_MAX = (GUARD_CYC > SETUP_CYC) ? GUARD_CYC : SETUP_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  seq_state_e state_q, state_n;
  seq_state_e guard_ret_q, guard_ret_n;
  logic [PH_W-1:0] ph_cnt_q;

  logic                 setup_done_c;
  logic                 guard_done_c;
  logic                 wd_clr_c;
  logic                 wd_en_c;
  logic                 wd_tc_c;
  logic                 accept_c;

  logic                 set_t_n;
  logic                 start_cal_n;
  logic                 cmd_ready_n;
  logic                 res_valid_n;
  logic                 timeout_n;
  logic [V_E_F_BIT-1:0] res_data_n;
  score_param_t         param_n;

  assign accept_c     = bus.i_cmd_valid && bus.o_cmd_ready;
  assign setup_done_c = (ph_cnt_q == PH_W'(SETUP_CYC - 1));
  assign guard_done_c = (ph_cnt_q == PH_W'(GUARD_CYC - 1));
  assign wd_clr_c     = (state_q != state_n);
  assign wd_en_c      = (state_q == ST_WVALID) || (state_q == ST_DRAIN);

  sw_host_sequencer_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr_c),
    .en    (wd_en_c),
    .tc_c  (wd_tc_c)
  );

  // State, guard return target and setup/guard phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      guard_ret_q <= ST_IDLE;
      ph_cnt_q    <= '0;
    end else begin
      state_q     <= state_n;
      guard_ret_q <= guard_ret_n;
      if (state_q != state_n) begin
        ph_cnt_q <= '0;
      end else if ((state_q == ST_SETUP) || (state_q == ST_GUARD)) begin
        ph_cnt_q <= ph_cnt_q + PH_W'(1);
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n     = state_q;
    guard_ret_n = guard_ret_q;
    param_n     = bus.o_param;
    res_data_n  = bus.o_res_data;
    res_valid_n = bus.o_res_valid && !bus.i_res_ready;
    timeout_n   = bus.o_timeout;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          timeout_n = 1'b0;
          if (bus.i_cmd_sett) begin
            state_n = ST_SPULSE;
          end else begin
            param_n = bus.i_cmd_param;
            state_n = ST_SETUP;
          end
        end
      end
      ST_SPULSE: begin
        guard_ret_n = ST_DRAIN;
        state_n     = ST_GUARD;
      end
      ST_SETUP: begin
        if (setup_done_c) state_n = ST_CPULSE;
      end
      ST_CPULSE: begin
        guard_ret_n = ST_WVALID;
        state_n     = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_done_c) state_n = guard_ret_q;
      end
      ST_WVALID: begin
        if (bus.i_valid) begin
          res_data_n  = bus.i_result;
          res_valid_n = 1'b1;
          state_n     = bus.i_busy ? ST_DRAIN : ST_IDLE;
        end else if (wd_tc_c) begin
          timeout_n = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!bus.i_busy) begin
          state_n = ST_IDLE;
        end else if (wd_tc_c) begin
          timeout_n = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    set_t_n     = (state_n == ST_SPULSE);
    start_cal_n = (state_n == ST_CPULSE);
    cmd_ready_n = (state_n == ST_IDLE) && !res_valid_n;
  end

  // Output registers; ready is precomputed so it matches the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_cmd_ready <= 1'b0;
      bus.o_res_valid <= 1'b0;
      bus.o_res_data  <= '0;
      bus.o_timeout   <= 1'b0;
      bus.o_set_t     <= 1'b0;
      bus.o_start_cal <= 1'b0;
      bus.o_param     <= '0;
    end else begin
      bus.o_cmd_ready <= cmd_ready_n;
      bus.o_res_valid <= res_valid_n;
      bus.o_res_data  <= res_data_n;
      bus.o_timeout   <= timeout_n;
      bus.o_set_t     <= set_t_n;
      bus.o_start_cal <= start_cal_n;
      bus.o_param     <= param_n;
    end
  end

endmodule
